// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the frame-atomic UART tx FIFO arbiter.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    PAD  = 2'd2
  } state_t;

  localparam logic [7:0] PAD_BYTE      = 8'h00;
  localparam logic [1:0] SETTLE_CYCLES = 2'd2;

  function automatic int unsigned wrap_inc(
    input int unsigned i,
    input int unsigned n
  );
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Round-robin first-one search over req, starting at ptr.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] idx,
  output logic          found
);

  int j;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && req[IW'(j)]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Frame-atomic arbiter sharing one UART tx FIFO between frame producers.
// Stalled frames time out and are zero-padded to keep line framing.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int FIFO_DEPTH = 4096,
  parameter int USEDW_W    = 12,
  parameter int TIMEOUT    = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*8-1:0]   req_len,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [NUM_REQ*8-1:0]   din,
  input  logic [NUM_REQ-1:0]     din_valid,
  output logic [NUM_REQ-1:0]     din_ready,
  output logic                   tx_fifo_wen,
  output logic [7:0]             tx_fifo_wdata,
  input  logic                   tx_fifo_full,
  input  logic [USEDW_W-1:0]     tx_fifo_usedw,
  output logic                   frame_done,
  output logic                   err_timeout
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SW = $clog2(TIMEOUT + 1);
  localparam int FW = USEDW_W + 1;

  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] sel;
  logic [IW-1:0] cand;
  logic [IW-1:0] sel_next;
  logic [IW-1:0] cand_next;
  logic          found;
  logic [1:0]    settle_cnt;
  logic [7:0]    remain;
  logic [7:0]    cand_len;
  logic [7:0]    cur_din;
  logic [SW-1:0] stall;
  logic [FW-1:0] free;
  logic [FW-1:0] need;
  logic          accept;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .idx   (cand),
    .found (found)
  );

  always_comb begin
    cand_len = '0;
    cur_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (cand == IW'(i)) cand_len = req_len[i*8 +: 8];
      if (sel == IW'(i))  cur_din  = din[i*8 +: 8];
    end
  end

  // Space left after the current fill, compared against the whole frame.
  assign free = FW'(FIFO_DEPTH - 1) - {1'b0, tx_fifo_usedw};
  assign need = FW'(cand_len);

  assign sel_next  = IW'(wrap_inc(32'(sel), NUM_REQ));
  assign cand_next = IW'(wrap_inc(32'(cand), NUM_REQ));

  always_comb begin
    din_ready = '0;
    if (state == XFER && remain != '0 && !tx_fifo_full)
      din_ready[sel] = 1'b1;
  end

  assign accept = |(din_valid & din_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      sel           <= '0;
      settle_cnt    <= '0;
      remain        <= '0;
      stall         <= '0;
      gnt           <= '0;
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= '0;
      frame_done    <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      tx_fifo_wen <= 1'b0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          gnt   <= '0;
          stall <= '0;
          if (settle_cnt != '0) begin
            settle_cnt <= settle_cnt - 2'd1;
          end else if (found && free >= need) begin
            gnt <= ONE << cand;
            sel <= cand;
            if (cand_len == '0) begin
              frame_done <= 1'b1;
              rr_ptr     <= cand_next;
              settle_cnt <= SETTLE_CYCLES;
            end else begin
              remain <= cand_len;
              state  <= XFER;
            end
          end
        end
        XFER: begin
          if (accept) begin
            tx_fifo_wen   <= 1'b1;
            tx_fifo_wdata <= cur_din;
            remain        <= remain - 8'd1;
            stall         <= '0;
            if (remain == 8'd1) begin
              frame_done <= 1'b1;
              gnt        <= '0;
              rr_ptr     <= sel_next;
              settle_cnt <= SETTLE_CYCLES;
              state      <= IDLE;
            end
          end else begin
            if (stall != SW'(TIMEOUT))
              stall <= stall + SW'(1);
            if (stall == SW'(TIMEOUT - 1)) begin
              state       <= PAD;
              err_timeout <= 1'b1;
              gnt         <= '0;
            end
          end
        end
        PAD: begin
          if (!tx_fifo_full && remain != '0) begin
            tx_fifo_wen   <= 1'b1;
            tx_fifo_wdata <= PAD_BYTE;
            remain        <= remain - 8'd1;
            if (remain == 8'd1) begin
              frame_done <= 1'b1;
              rr_ptr     <= sel_next;
              settle_cnt <= SETTLE_CYCLES;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Randomized and directed bench for uart_tx_arb against a frame-level model.
module tb_uart_tx_arb;

  localparam int NR    = 2;
  localparam int DEPTH = 4096;
  localparam int UW    = 12;
  localparam int TO    = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req;
  logic [NR*8-1:0] req_len;
  logic [NR-1:0]   gnt;
  logic [NR*8-1:0] din;
  logic [NR-1:0]   din_valid;
  logic [NR-1:0]   din_ready;
  logic            tx_fifo_wen;
  logic [7:0]      tx_fifo_wdata;
  logic            tx_fifo_full;
  logic [UW-1:0]   tx_fifo_usedw;
  logic            frame_done;
  logic            err_timeout;

  uart_tx_arb #(
    .NUM_REQ    (NR),
    .FIFO_DEPTH (DEPTH),
    .USEDW_W    (UW),
    .TIMEOUT    (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_len       (req_len),
    .gnt           (gnt),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .tx_fifo_wen   (tx_fifo_wen),
    .tx_fifo_wdata (tx_fifo_wdata),
    .tx_fifo_full  (tx_fifo_full),
    .tx_fifo_usedw (tx_fifo_usedw),
    .frame_done    (frame_done),
    .err_timeout   (err_timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int ncyc  = 0;
  bit armed = 1'b0;

  // frame-level model state
  bit          m_busy, m_pad;
  int          m_who, m_left, m_idle, m_cool, m_ptr;
  logic [NR-1:0] m_gnt, m_rdy;
  logic        m_wen, m_done, m_to;
  logic [7:0]  m_wdata;

  // producers
  bit   pend[NR];
  int   plen[NR];
  bit   hold[NR];
  bit   rfull, rmode;
  logic [7:0] src0[$];
  logic [7:0] src1[$];

  logic [7:0] wlog[$];
  logic [7:0] exp_q[$];
  int n_done, n_to;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic chk_log(string nm);
    chk({nm, "_len"}, wlog.size(), exp_q.size());
    foreach (exp_q[i])
      chk(nm, (i < wlog.size()) ? 32'(wlog[i]) : 32'hdeadbeef, 32'(exp_q[i]));
  endtask

  // Model: whole frames granted in rr order only when they fit; bytes
  // follow the grant; TO silent cycles turn the rest into zero bytes.
  always @(posedge clk) begin
    int c, room, ln;
    m_wen  = 1'b0;
    m_done = 1'b0;
    m_to   = 1'b0;
    if (rst) begin
      m_busy = 0; m_pad = 0; m_left = 0; m_idle = 0;
      m_cool = 0; m_ptr = 0; m_gnt = '0;
    end else if (!m_busy) begin
      m_gnt = '0;
      if (m_cool > 0) begin
        m_cool--;
      end else begin
        c = -1;
        for (int k = 0; k < NR; k++)
          if (c < 0 && req[(m_ptr + k) % NR]) c = (m_ptr + k) % NR;
        room = DEPTH - 1 - int'(tx_fifo_usedw);
        if (c >= 0) begin
          ln = int'(req_len[c*8 +: 8]);
          if (room >= ln) begin
            m_gnt[c] = 1'b1;
            if (ln == 0) begin
              m_done = 1'b1; m_ptr = (c + 1) % NR; m_cool = 2;
            end else begin
              m_busy = 1; m_pad = 0; m_who = c; m_left = ln; m_idle = 0;
            end
          end
        end
      end
    end else if (!m_pad) begin
      if (din_valid[m_who] && !tx_fifo_full) begin
        m_wen = 1'b1; m_wdata = din[m_who*8 +: 8];
        m_left--; m_idle = 0;
        if (m_left == 0) begin
          m_done = 1'b1; m_gnt = '0; m_busy = 0;
          m_ptr = (m_who + 1) % NR; m_cool = 2;
        end
      end else begin
        m_idle++;
        if (m_idle == TO) begin
          m_pad = 1; m_to = 1'b1; m_gnt = '0;
        end
      end
    end else if (!tx_fifo_full) begin
      m_wen = 1'b1; m_wdata = 8'h00; m_left--;
      if (m_left == 0) begin
        m_done = 1'b1; m_busy = 0; m_pad = 0;
        m_ptr = (m_who + 1) % NR; m_cool = 2;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    ncyc++;
    if (armed) begin
      m_rdy = '0;
      if (m_busy && !m_pad && m_left > 0 && !tx_fifo_full) m_rdy[m_who] = 1'b1;
      chk("gnt", gnt, m_gnt);
      chk("wen", tx_fifo_wen, m_wen);
      if (m_wen) chk("wdata", tx_fifo_wdata, m_wdata);
      chk("frame_done", frame_done, m_done);
      chk("err_timeout", err_timeout, m_to);
      chk("din_ready", din_ready, m_rdy);
    end
    if (tx_fifo_wen === 1'b1) wlog.push_back(tx_fifo_wdata);
    if (frame_done === 1'b1) n_done++;
    if (err_timeout === 1'b1) n_to++;
  end

  task automatic cyc();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (gnt[i]) pend[i] = 1'b0;
      req[i] = pend[i];
      req_len[i*8 +: 8] = 8'(plen[i]);
      hold[i] = rmode && ($urandom_range(0, 4) == 0);
    end
    din_valid[0] = (src0.size() > 0) && !hold[0];
    din_valid[1] = (src1.size() > 0) && !hold[1];
    din[7:0]  = (src0.size() > 0) ? src0[0] : 8'h00;
    din[15:8] = (src1.size() > 0) ? src1[0] : 8'h00;
    tx_fifo_full = rfull && ($urandom_range(0, 9) == 0);
    #2;
    if (din_valid[0] && din_ready[0]) void'(src0.pop_front());
    if (din_valid[1] && din_ready[1]) void'(src1.pop_front());
  endtask

  task automatic do_reset();
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0; plen[i] = 0; hold[i] = 1'b0;
    end
    src0.delete(); src1.delete();
    rfull = 1'b0;
    tx_fifo_usedw = '0;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    wlog.delete();
    n_done = 0;
    n_to = 0;
  endtask

  task automatic wait_done(string nm, int n, int budget);
    int cnt;
    cnt = 0;
    while (n_done < n && cnt < budget) begin
      cyc();
      cnt++;
    end
    chk(nm, n_done, n);
  endtask

  initial begin
    int t_d, t_g, t_w2, t_to, cnt, nreq, start_done, ln, nb;
    logic [NR-1:0] seen;
    rst = 1'b1; req = '0; req_len = '0; din = '0; din_valid = '0;
    tx_fifo_full = 1'b0; tx_fifo_usedw = '0; rfull = 1'b0; rmode = 1'b0;
    n_done = 0; n_to = 0;
    @(negedge clk);
    armed = 1'b1;

    do_reset();
    chk("rst_gnt", gnt, 0);
    chk("rst_wen", tx_fifo_wen, 0);
    chk("rst_wdata", tx_fifo_wdata, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_to", err_timeout, 0);
    chk("rst_ready", din_ready, 0);

    // single frame of five bytes
    pend[0] = 1'b1; plen[0] = 5;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      src0.push_back(8'(8'h11 + i));
      exp_q.push_back(8'(8'h11 + i));
    end
    cyc();
    cyc();
    chk("t1_gnt", gnt, 2'b01);
    wait_done("t1_done", 1, 40);
    chk("t1_gnt_drop", gnt, 0);
    chk_log("t1_bytes");

    // contention, rr_ptr starts at 0
    do_reset();
    pend[0] = 1'b1; plen[0] = 3;
    pend[1] = 1'b1; plen[1] = 3;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      src0.push_back(8'(8'hA0 + i));
      exp_q.push_back(8'(8'hA0 + i));
    end
    for (int i = 0; i < 3; i++) begin
      src1.push_back(8'(8'hB0 + i));
      exp_q.push_back(8'(8'hB0 + i));
    end
    t_d = -1; t_g = -1; cnt = 0;
    while (n_done < 2 && cnt < 60) begin
      cyc();
      cnt++;
      if (n_done >= 1 && t_d < 0) t_d = ncyc;
      if (gnt[1] && t_g < 0) t_g = ncyc;
    end
    chk("t3_done", n_done, 2);
    chk("t3_gap", (t_g - t_d >= 3) ? 1 : 0, 1);
    chk_log("t3_bytes");

    // space check with head-of-line hold
    do_reset();
    tx_fifo_usedw = 12'd4090;
    pend[0] = 1'b1; plen[0] = 10;
    pend[1] = 1'b1; plen[1] = 1;
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      src0.push_back(8'(8'h40 + i));
      exp_q.push_back(8'(8'h40 + i));
    end
    src1.push_back(8'h77);
    exp_q.push_back(8'h77);
    seen = '0;
    repeat (8) begin
      cyc();
      seen = seen | gnt;
    end
    chk("t4_hold", seen, 0);
    tx_fifo_usedw = 12'd4085;
    cyc();
    chk("t4_gnt", gnt, 2'b01);
    wait_done("t4_done", 2, 80);
    chk_log("t4_bytes");

    // timeout and zero padding
    do_reset();
    pend[0] = 1'b1; plen[0] = 4;
    src0.push_back(8'hC1);
    src0.push_back(8'hC2);
    exp_q.delete();
    exp_q.push_back(8'hC1);
    exp_q.push_back(8'hC2);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    t_w2 = -1; t_to = -1; cnt = 0;
    while (n_done < 1 && cnt < 60) begin
      cyc();
      cnt++;
      if (wlog.size() >= 2 && t_w2 < 0) t_w2 = ncyc;
      if (n_to >= 1 && t_to < 0) t_to = ncyc;
    end
    chk("t5_done", n_done, 1);
    chk("t5_to_cnt", n_to, 1);
    chk("t5_delay", t_to - t_w2, TO);
    chk_log("t5_bytes");

    // zero-length frame
    do_reset();
    pend[0] = 1'b1; plen[0] = 0;
    cyc();
    cyc();
    chk("t6_gnt", gnt, 2'b01);
    chk("t6_done", frame_done, 1);
    chk("t6_wen", tx_fifo_wen, 0);
    cyc();
    chk("t6_gnt_drop", gnt, 0);
    repeat (4) cyc();
    chk("t6_ndone", n_done, 1);
    chk("t6_nbytes", wlog.size(), 0);

    // reset in the middle of a frame
    do_reset();
    pend[0] = 1'b1; plen[0] = 5;
    for (int i = 0; i < 5; i++) src0.push_back(8'(8'hD1 + i));
    cnt = 0;
    while (wlog.size() < 2 && cnt < 20) begin
      cyc();
      cnt++;
    end
    rst = 1'b1;
    cyc();
    chk("t7_gnt", gnt, 0);
    chk("t7_wen", tx_fifo_wen, 0);
    chk("t7_done", frame_done, 0);
    chk("t7_to", err_timeout, 0);
    chk("t7_ready", din_ready, 0);
    rst = 1'b0;
    pend[0] = 1'b0;
    src0.delete();
    repeat (25) cyc();
    chk("t7_nbytes", wlog.size(), 2);
    chk("t7_no_pad", n_to, 0);

    // randomized rounds
    do_reset();
    rmode = 1'b1;
    rfull = 1'b1;
    for (int r = 0; r < 40; r++) begin
      nreq = 0;
      if ($urandom_range(0, 2) == 0)
        tx_fifo_usedw = UW'($urandom_range(3990, 4095));
      else
        tx_fifo_usedw = UW'($urandom_range(0, 100));
      for (int i = 0; i < NR; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          ln = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
          nb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, ln)) : ln;
          pend[i] = 1'b1;
          plen[i] = ln;
          nreq++;
          for (int b = 0; b < nb; b++) begin
            if (i == 0) src0.push_back(8'($urandom));
            else        src1.push_back(8'($urandom));
          end
        end
      end
      start_done = n_done;
      cnt = 0;
      while (n_done - start_done < nreq && cnt < 300) begin
        cyc();
        cnt++;
        if (cnt == 40) tx_fifo_usedw = '0;
      end
      chk("rnd_frames", n_done - start_done, nreq);
      for (int i = 0; i < NR; i++) pend[i] = 1'b0;
      src0.delete();
      src1.delete();
      repeat (3) cyc();
    end
    rmode = 1'b0;
    rfull = 1'b0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1);
  end

endmodule
